// File: rtl/tristate_bus_arbiter_if.sv
// Bus-side signals of the tri-state bus arbiter: source requests in, grants/enables/select out.
// master is the arbiter's view; slave is the sources' / downstream mux view.
interface tristate_bus_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [N-1:0]  oe;
    logic [SW-1:0] sel;
    logic          sel_valid;
    logic          timeout;

    modport master (
        input  req,
        output grant,
        output oe,
        output sel,
        output sel_valid,
        output timeout
    );

    modport slave (
        output req,
        input  grant,
        input  oe,
        input  sel,
        input  sel_valid,
        input  timeout
    );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus: one-hot enables, a fixed all-released
// turnaround gap between owners, and an optional per-ownership hold timeout.
module tristate_bus_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned MAX_HOLD   = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    tristate_bus_arbiter_if.master bus
);
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [3:0]  TurnLast = 4'(TURNAROUND);
    localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);
    localparam logic [SW-1:0] LastIdx = SW'(N - 1);

    typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

    state_e        state_q;
    logic [SW-1:0] ptr_q;
    logic [HW-1:0] hold_q;
    logic [3:0]    turn_q;
    logic [N-1:0]  grant_q;
    logic [SW-1:0] sel_q;
    logic          sel_valid_q;
    logic          timeout_q;

    logic [SW-1:0] win;
    logic          any_req;
    logic          owner_req;
    logic          do_grant;
    logic          hold_expired;
    logic [SW-1:0] ptr_wrap;

    // Scan upward from the pointer, wrapping modulo N; first set request wins.
    always_comb begin
        int idx;
        logic [SW-1:0] cand;
        win     = '0;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int i = 0; i < int'(N); i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= int'(N)) idx = idx - int'(N);
            cand = SW'(idx);
            if (!any_req && bus.req[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        owner_req    = bus.req[sel_q];
        hold_expired = (MAX_HOLD != 0) && (hold_q == HoldMax);
        ptr_wrap     = (sel_q == LastIdx) ? '0 : sel_q + SW'(1);
        do_grant     = any_req && ((state_q == StIdle) ||
                                   (state_q == StTurn && turn_q == TurnLast));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            hold_q      <= '0;
            turn_q      <= '0;
            grant_q     <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (do_grant) begin
                state_q     <= StOwn;
                grant_q     <= {{(N-1){1'b0}}, 1'b1} << win;
                sel_q       <= win;
                sel_valid_q <= 1'b1;
                hold_q      <= HW'(1);
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StOwn: begin
                        if (!owner_req || hold_expired) begin
                            // Owner drops to lowest priority; sel keeps its index for the mux.
                            state_q     <= StTurn;
                            grant_q     <= '0;
                            sel_valid_q <= 1'b0;
                            ptr_q       <= ptr_wrap;
                            turn_q      <= 4'd1;
                            timeout_q   <= owner_req;
                        end else if (hold_q != '1) begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    StTurn: begin
                        if (turn_q == TurnLast) state_q <= StIdle;
                        else                    turn_q  <= turn_q + 4'd1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.grant     = grant_q;
    assign bus.oe        = grant_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N=4, TURNAROUND=1, MAX_HOLD=8).
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_tristate_bus_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    tristate_bus_arbiter_if #(.N(4)) bus ();

    tristate_bus_arbiter #(
        .N          (4),
        .TURNAROUND (1),
        .MAX_HOLD   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_owner(input string tag, input logic [3:0] g, input logic [1:0] s);
        check({tag, ".grant"}, 32'(bus.grant), 32'(g));
        check({tag, ".oe"}, 32'(bus.oe), 32'(g));
        check({tag, ".sel"}, 32'(bus.sel), 32'(s));
        check({tag, ".sel_valid"}, 32'(bus.sel_valid), 32'(g != 4'b0000));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.req = '0;

        // Reset state
        step();
        step();
        check("rst.grant", 32'(bus.grant), 32'h0);
        check("rst.oe", 32'(bus.oe), 32'h0);
        check("rst.sel", 32'(bus.sel), 32'h0);
        check("rst.sel_valid", 32'(bus.sel_valid), 32'h0);
        check("rst.timeout", 32'(bus.timeout), 32'h0);
        rst_n = 1'b1;

        // Asynchronous reset mid-ownership
        bus.req = 4'b0010;
        step();
        check_owner("async.own", 4'b0010, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async.oe", 32'(bus.oe), 32'h0);
        check("async.grant", 32'(bus.grant), 32'h0);
        check("async.sel_valid", 32'(bus.sel_valid), 32'h0);
        bus.req = '0;
        #1 rst_n = 1'b1;

        // Single requester: owns three cycles, then one TURN cycle, then IDLE
        do_reset();
        bus.req = 4'b0001;
        step();
        check_owner("single.c1", 4'b0001, 2'd0);
        step();
        check_owner("single.c2", 4'b0001, 2'd0);
        step();
        check_owner("single.c3", 4'b0001, 2'd0);
        bus.req = 4'b0000;
        step();
        check_owner("single.turn", 4'b0000, 2'd0);
        step();
        check_owner("single.idle", 4'b0000, 2'd0);
        bus.req = 4'b0010;
        step();
        check_owner("single.after", 4'b0010, 2'd1);

        // Simultaneous requests serviced 0,1,2,3 with a one-cycle gap
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            check_owner($sformatf("rr.own%0d.a", k), 4'(1 << k), 2'(k));
            step();
            check_owner($sformatf("rr.own%0d.b", k), 4'(1 << k), 2'(k));
            bus.req[k] = 1'b0;
            step();
            check_owner($sformatf("rr.gap%0d", k), 4'b0000, 2'(k));
        end
        step();
        check_owner("rr.idle", 4'b0000, 2'd3);

        // Timeout: exactly 8 granted cycles, a one-cycle pulse, then re-grant
        do_reset();
        bus.req = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_owner($sformatf("to.hold%0d", k), 4'b0100, 2'd2);
            check($sformatf("to.notimeout%0d", k), 32'(bus.timeout), 32'h0);
        end
        step();
        check_owner("to.forced", 4'b0000, 2'd2);
        check("to.pulse", 32'(bus.timeout), 32'h1);
        step();
        check_owner("to.regrant", 4'b0100, 2'd2);
        check("to.pulse_end", 32'(bus.timeout), 32'h0);

        // Fairness: source 2 forced off hands over to source 0
        bus.req = 4'b0101;
        for (int k = 2; k <= 8; k++) step();
        check_owner("fair.last", 4'b0100, 2'd2);
        step();
        check_owner("fair.forced", 4'b0000, 2'd2);
        check("fair.pulse", 32'(bus.timeout), 32'h1);
        step();
        check_owner("fair.next", 4'b0001, 2'd0);

        // Wrap-around: owner 3 releases, source 0 wins over nothing higher
        do_reset();
        bus.req = 4'b1000;
        step();
        check_owner("wrap.own3", 4'b1000, 2'd3);
        bus.req = 4'b1001;
        step();
        check_owner("wrap.hold3", 4'b1000, 2'd3);
        bus.req = 4'b0001;
        step();
        check_owner("wrap.gap", 4'b0000, 2'd3);
        step();
        check_owner("wrap.next", 4'b0001, 2'd0);

        // Forced release of owner 3 with 1001: pointer wraps to 0 so source 0 wins
        do_reset();
        bus.req = 4'b1000;
        step();
        bus.req = 4'b1001;
        for (int k = 2; k <= 8; k++) step();
        check_owner("wrapto.last", 4'b1000, 2'd3);
        step();
        check("wrapto.pulse", 32'(bus.timeout), 32'h1);
        step();
        check_owner("wrapto.next", 4'b0001, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
